// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg
// Shared definitions for the LCD image controller: command codes, controller
// states and the AVG rounding constant.
package lcd_ctrl_pkg;

    // Command codes carried on cmd[3:0]; codes 10..15 are treated as NOP.
    typedef enum logic [3:0] {
        CMD_WRITE  = 4'd0,
        CMD_UP     = 4'd1,
        CMD_DOWN   = 4'd2,
        CMD_LEFT   = 4'd3,
        CMD_RIGHT  = 4'd4,
        CMD_AVG    = 4'd5,
        CMD_MIRX   = 4'd6,
        CMD_MIRY   = 4'd7,
        CMD_ROTCW  = 4'd8,
        CMD_ROTCCW = 4'd9
    } cmd_e;

    // Controller states. The encoding is visible on the dbg_state port.
    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_IDLE  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Added to the 4-pixel sum before the divide-by-4; 0 gives floor().
    localparam int AVG_RND = 0;

endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu
// Purely combinational 2x2 window operator. Takes the four window pixels and
// the command code, returns the four new window pixels. Commands that do not
// modify the window pass the pixels through unchanged.
//
// Ports:
//   cmd                       command code (lcd_ctrl_pkg::cmd_e values)
//   tl, tr, bl, br            current window pixels
//   n_tl, n_tr, n_bl, n_br    new window pixels
//
// Build option: LCD_CTRL_ROT_EN enables ROTCW/ROTCCW. When undefined those
// codes pass through and no rotate muxing exists.
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    cmd,
    input  logic [DW-1:0] tl,
    input  logic [DW-1:0] tr,
    input  logic [DW-1:0] bl,
    input  logic [DW-1:0] br,
    output logic [DW-1:0] n_tl,
    output logic [DW-1:0] n_tr,
    output logic [DW-1:0] n_bl,
    output logic [DW-1:0] n_br
);

    // Two guard bits so four full-scale pixels cannot overflow.
    logic [DW+1:0] sum;
    logic [DW-1:0] avg;

    assign sum = (DW+2)'(tl) + (DW+2)'(tr) + (DW+2)'(bl) + (DW+2)'(br)
               + (DW+2)'(AVG_RND);
    assign avg = sum[DW+1:2];

    always_comb begin
        n_tl = tl;
        n_tr = tr;
        n_bl = bl;
        n_br = br;
        case (cmd)
            CMD_AVG: begin
                n_tl = avg;
                n_tr = avg;
                n_bl = avg;
                n_br = avg;
            end
            CMD_MIRX: begin
                n_tl = bl;
                n_bl = tl;
                n_tr = br;
                n_br = tr;
            end
            CMD_MIRY: begin
                n_tl = tr;
                n_tr = tl;
                n_bl = br;
                n_br = bl;
            end
`ifdef LCD_CTRL_ROT_EN
            CMD_ROTCW: begin
                n_tr = tl;
                n_br = tr;
                n_bl = br;
                n_tl = bl;
            end
            CMD_ROTCCW: begin
                n_tl = tr;
                n_tr = br;
                n_br = bl;
                n_bl = tl;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// lcd_ctrl_gen
// LCD image controller. After reset it copies an IMG_N x IMG_N image from the
// source ROM into an internal buffer, then executes single-cycle commands on
// a 2x2 window around a movable point, and on WRITE streams the whole buffer
// out to the result port.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   cmd          command code, cmd_valid strobe (sampled only while busy=0)
//   IROM_Q       source data, one cycle after IROM_A
//   IROM_EN      active-low source read enable, IROM_A source address
//   IRB_RW       result write strobe (0=write), IRB_D data, IRB_A address
//   busy         1 whenever a command cannot be accepted
//   done         one-cycle pulse after the last result write
//   dbg_state    current controller state (lcd_ctrl_pkg::state_e encoding)
//
// Handshake: a command is taken on a rising edge where cmd_valid=1 and
// busy=0; busy is 1 from the next cycle until the command finishes, and any
// cmd_valid seen while busy=1 is dropped (no queueing).
//
// Build option: LCD_CTRL_ROT_EN enables the ROTCW/ROTCCW commands.
module lcd_ctrl_gen
    import lcd_ctrl_pkg::*;
#(
    parameter  int IMG_N = 8,
    parameter  int DW    = 8,
    localparam int AW    = 2 * $clog2(IMG_N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [DW-1:0] IRB_D,
    output logic [AW-1:0] IRB_A,
    output logic          busy,
    output logic          done,
    output logic [2:0]    dbg_state
);

    localparam int              L     = $clog2(IMG_N);
    localparam int              N2    = IMG_N * IMG_N;
    localparam logic [L-1:0]    P_MIN = L'(1);
    localparam logic [L-1:0]    P_MAX = L'(IMG_N - 1);
    localparam logic [L-1:0]    P_MID = L'(IMG_N / 2);
    localparam logic [AW-1:0]   A_LAST = AW'(N2 - 1);
    localparam logic [AW:0]     LD_END = (AW+1)'(N2 + 1);

    state_e          state;
    logic [L-1:0]    px;
    logic [L-1:0]    py;
    logic [3:0]      cmd_r;
    logic [AW:0]     lcnt;
    logic [DW-1:0]   img [N2];

    // Window addresses: with IMG_N a power of two, y*IMG_N+x is {y, x}.
    logic [L-1:0]    xm1;
    logic [L-1:0]    ym1;
    logic [AW-1:0]   a_tl;
    logic [AW-1:0]   a_tr;
    logic [AW-1:0]   a_bl;
    logic [AW-1:0]   a_br;
    logic [AW-1:0]   wa_next;
    logic [AW-1:0]   ld_a;
    logic [DW-1:0]   n_tl;
    logic [DW-1:0]   n_tr;
    logic [DW-1:0]   n_bl;
    logic [DW-1:0]   n_br;

    assign xm1     = px - 1'b1;
    assign ym1     = py - 1'b1;
    assign a_tl    = {ym1, xm1};
    assign a_tr    = {ym1, px};
    assign a_bl    = {py, xm1};
    assign a_br    = {py, px};
    assign wa_next = IRB_A + 1'b1;
    // ROM data lags its address by one cycle and the address register lags
    // the counter by one more, so the pixel arriving now belongs to lcnt-2.
    assign ld_a    = lcnt[AW-1:0] - AW'(2);

    assign dbg_state = state;

    lcd_win_alu #(.DW(DW)) u_alu (
        .cmd  (cmd_r),
        .tl   (img[a_tl]),
        .tr   (img[a_tr]),
        .bl   (img[a_bl]),
        .br   (img[a_br]),
        .n_tl (n_tl),
        .n_tr (n_tr),
        .n_bl (n_bl),
        .n_br (n_br)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_LOAD;
            IROM_EN <= 1'b1;
            IROM_A  <= '0;
            IRB_RW  <= 1'b1;
            IRB_A   <= '0;
            IRB_D   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            px      <= P_MID;
            py      <= P_MID;
            cmd_r   <= '0;
            lcnt    <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    lcnt <= lcnt + 1'b1;
                    if (lcnt >= (AW+1)'(2)) begin
                        img[ld_a] <= IROM_Q;
                    end
                    if (lcnt == LD_END) begin
                        IROM_EN <= 1'b1;
                        IROM_A  <= '0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        IROM_EN <= 1'b0;
                        // Hold the last address during the extra capture cycle.
                        IROM_A  <= (lcnt < (AW+1)'(N2)) ? lcnt[AW-1:0] : A_LAST;
                    end
                end

                S_IDLE: begin
                    if (cmd_valid) begin
                        busy <= 1'b1;
                        if (cmd == CMD_WRITE) begin
                            IRB_RW <= 1'b0;
                            IRB_A  <= '0;
                            IRB_D  <= img[0];
                            state  <= S_WRITE;
                        end else begin
                            cmd_r <= cmd;
                            state <= S_EXEC;
                        end
                    end
                end

                S_EXEC: begin
                    case (cmd_r)
                        CMD_UP:    if (py != P_MIN) py <= py - 1'b1;
                        CMD_DOWN:  if (py != P_MAX) py <= py + 1'b1;
                        CMD_LEFT:  if (px != P_MIN) px <= px - 1'b1;
                        CMD_RIGHT: if (px != P_MAX) px <= px + 1'b1;
                        default: begin
                            // Non-window codes come back from the ALU unchanged.
                            img[a_tl] <= n_tl;
                            img[a_tr] <= n_tr;
                            img[a_bl] <= n_bl;
                            img[a_br] <= n_br;
                        end
                    endcase
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                S_WRITE: begin
                    if (IRB_A == A_LAST) begin
                        IRB_RW <= 1'b1;
                        IRB_A  <= '0;
                        IRB_D  <= '0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        IRB_A <= wa_next;
                        IRB_D <= img[wa_next];
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b1;
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_ctrl_gen.md
LCD_CTRL_GEN -- requirements
Module: lcd_ctrl_gen

Interface
REQ-001 Parameter IMG_N, default 8, meaning image side length in pixels; power of two, 4..32.
REQ-002 Parameter DW, default 8, meaning pixel data width in bits.
REQ-003 Localparam AW = 2*log2(IMG_N), meaning pixel address width, 6 at default.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd  input  4  command code; decoding is in REQ-014.
REQ-007 cmd_valid  input  1  command strobe, sampled only while busy=0.
REQ-008 IROM_Q  input  DW  source image data, valid one cycle after IROM_A.
REQ-009 IROM_EN  output  1  active-low source read enable.
REQ-010 IROM_A  output  AW  source read address.
REQ-011 IRB_RW  output  1  result write strobe; 0=write, 1=idle.
REQ-012 IRB_D  output  DW  result write data; 0 when IRB_RW=1.
REQ-013 IRB_A  output  AW  result write address. busy  output  1  command not accepted. done  output  1  write-out complete pulse.

Function
REQ-014 Command codes SHALL be: 0 WRITE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 AVG, 6 MIRX, 7 MIRY, 8 ROTCW, 9 ROTCCW; 10-15 are NOP.
REQ-015 State machine SHALL be LOAD -> IDLE -> EXEC -> IDLE, or LOAD -> IDLE -> WRITE -> DONE -> IDLE.
REQ-016 LOAD SHALL drive IROM_EN=0 and sweep IROM_A 0..IMG_N^2-1, storing IROM_Q at address a-1 each cycle; total IMG_N^2+1 cycles, then IROM_EN=1 and enter IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 A command is accepted on the edge where cmd_valid=1 and busy=0; busy SHALL be 1 on the next cycle.
REQ-019 cmd_valid while busy=1 SHALL be ignored, with no queuing.
REQ-020 Point (x,y) SHALL reset to (IMG_N/2, IMG_N/2).
REQ-021 The operation window is pixels TL=(x-1,y-1), TR=(x,y-1), BL=(x-1,y), BR=(x,y); address = y*IMG_N+x.
REQ-022 UP/DOWN/LEFT/RIGHT SHALL step y-1/y+1/x-1/x+1, saturating at 1 and IMG_N-1; a move at the limit is a legal no-op.
REQ-023 AVG SHALL write floor((TL+TR+BL+BR)/4) to all four window pixels; the sum is computed in DW+2 bits.
REQ-024 MIRX SHALL swap TL with BL and TR with BR; MIRY SHALL swap TL with TR and BL with BR.
REQ-025 ROTCW SHALL apply TR<-TL, BR<-TR, BL<-BR, TL<-BL; ROTCCW SHALL apply the inverse.
REQ-026 All EXEC commands, including NOP, SHALL complete in exactly 1 cycle; busy SHALL be 0 on the second cycle after acceptance.
REQ-027 WRITE SHALL drive IRB_RW=0 for IMG_N^2 consecutive cycles with IRB_A=0..IMG_N^2-1 and IRB_D=buffer[IRB_A].
REQ-028 done SHALL pulse high for exactly 1 cycle in DONE; the block then returns to IDLE and accepts further commands.

Reset
REQ-029 On reset: IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, busy=1, done=0, point per REQ-020, state=LOAD.
REQ-030 After release, LOAD SHALL begin on the first cycle with reset=0.
REQ-031 Reset asserted in any state, including mid-WRITE, SHALL abort the operation and force the REQ-029 values on the next edge.
REQ-032 The image buffer SHALL NOT be reset; LOAD overwrites it.

Configuration
REQ-033 Macro LCD_CTRL_ROT_EN defined: ROTCW/ROTCCW SHALL behave per REQ-025.
REQ-034 LCD_CTRL_ROT_EN undefined: codes 8 and 9 SHALL be NOP per REQ-026, and no rotate logic SHALL be synthesised.

Structure
REQ-035 Package lcd_ctrl_pkg SHALL hold the command enum, the state enum, and the AVG rounding constant.
REQ-036 Sub-module lcd_win_alu SHALL be combinational: 4 window pixels plus cmd in, 4 new window pixels out.

Verification
REQ-037 Test 1: IMG_N=8, DW=8, IROM[a]=a; reset, wait for busy=0, issue WRITE -> IRB_D=a at each IRB_A=a for 64 cycles, then one done pulse.
REQ-038 Test 2: AVG at (4,4), window addresses 27/28/35/36 -> all four become 31; after WRITE, address 28 reads 31.
REQ-039 Test 3: LEFT x5 then UP x5 -> point (1,1); then AVG -> addresses 0/1/8/9 become floor(18/4)=4.
REQ-040 Test 4: MIRX at (4,4) -> address 27=35 and 36=28; a second MIRX restores the original values.
REQ-041 Test 5: ROTCW at (4,4) with LCD_CTRL_ROT_EN -> 28=27, 36=28, 35=36, 27=35; without the macro -> window unchanged, busy=1 for 1 cycle.
REQ-042 Test 6: reset at IRB_A=20 mid-WRITE -> IRB_RW=1 and IRB_A=0 next cycle, LOAD restarts, no done pulse; cmd_valid while busy=1 is ignored.
